// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter
//   Round-robin arbiter sharing one RAM port between instruction fetch and
//   load/store, with per-access sequencing, timeout and pipeline stall control.
//   Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_done,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  input  logic          ram_ack,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          wb_bubble,
  output logic          err
);

  localparam int            CW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] C_CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_BUSY_IF  = 2'd1,
    S_BUSY_MEM = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_last_mem;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_ram_addr;
  logic [DW-1:0]   r_ram_wdata;
  logic [DW-1:0]   r_if_rdata;
  logic [DW-1:0]   r_mem_rdata;
  logic            r_ram_en;
  logic            r_ram_we;
  logic            r_if_valid;
  logic            r_mem_done;
  logic            r_err;
  logic            w_grant_if;
  logic            w_grant_mem;
  logic            w_finish;
  logic            w_timeout;

  assign w_timeout = (TIMEOUT != 0) && (r_cnt == C_CNT_LAST);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_if  = 1'b0;
    w_grant_mem = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // On contention the side that did not win last time gets the port
        if (mem_req && (!if_req || !r_last_mem)) begin
          w_grant_mem = 1'b1;
          w_state_nxt = S_BUSY_MEM;
        end else if (if_req) begin
          w_grant_if  = 1'b1;
          w_state_nxt = S_BUSY_IF;
        end
      end
      S_BUSY_IF, S_BUSY_MEM: begin
        if (ram_ack || w_timeout) begin
          w_finish    = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_last_mem  <= 1'b0;
      r_cnt       <= '0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_if_valid  <= 1'b0;
      r_mem_done  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_mem_done <= 1'b0;
      if (r_state == S_IDLE) begin
        r_cnt <= '0;
        if (w_grant_mem) begin
          r_ram_en    <= 1'b1;
          r_ram_we    <= mem_we;
          r_ram_addr  <= mem_addr;
          r_ram_wdata <= mem_wdata;
          r_last_mem  <= 1'b1;
        end else if (w_grant_if) begin
          r_ram_en    <= 1'b1;
          r_ram_we    <= 1'b0;
          r_ram_addr  <= if_addr;
          r_ram_wdata <= '0;
          r_last_mem  <= 1'b0;
        end
      end else if (r_state != S_DONE) begin
        r_cnt <= r_cnt + CW'(1);
        if (w_finish) begin
          r_ram_en <= 1'b0;
          r_ram_we <= 1'b0;
          // An ack in the last allowed cycle still wins over the timeout
          if (!ram_ack) begin
            r_err <= 1'b1;
          end
          if (r_state == S_BUSY_IF) begin
            r_if_rdata <= ram_ack ? ram_rdata : '0;
            r_if_valid <= 1'b1;
          end else begin
            if (!ram_ack) begin
              r_mem_rdata <= '0;
            end else if (!r_ram_we) begin
              r_mem_rdata <= ram_rdata;
            end
            r_mem_done <= 1'b1;
          end
        end
      end
    end
  end

  assign ram_en    = r_ram_en;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign if_rdata  = r_if_rdata;
  assign if_valid  = r_if_valid;
  assign mem_rdata = r_mem_rdata;
  assign mem_done  = r_mem_done;
  assign err       = r_err;

  assign stall_mem = mem_req & ~r_mem_done;
  assign wb_bubble = stall_mem;
  assign stall_if  = (if_req & ~r_if_valid) | stall_mem;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter
//   Self-checking bench: directed scenarios plus randomized traffic against a
//   transaction-level reference model.   Revision: 1.0
// ============================================================================
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          clr;
  logic          if_req, mem_req, mem_we, ram_ack;
  logic [AW-1:0] if_addr, mem_addr;
  logic [DW-1:0] mem_wdata, ram_rdata;
  logic [DW-1:0] if_rdata, mem_rdata, ram_wdata;
  logic [AW-1:0] ram_addr;
  logic          if_valid, mem_done, ram_en, ram_we;
  logic          stall_if, stall_mem, wb_bubble, err;

  int total = 0;
  int bad   = 0;

  // Reference model state (transaction level)
  logic          m_last_mem;
  logic          m_err;
  logic [DW-1:0] m_if_rdata, m_mem_rdata;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .clr(clr),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack),
    .stall_if(stall_if), .stall_mem(stall_mem), .wb_bubble(wb_bubble), .err(err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_last_mem  = 1'b0;
    m_err       = 1'b0;
    m_if_rdata  = '0;
    m_mem_rdata = '0;
  endtask

  // Winner: 1 = fetch, 2 = load/store, 0 = nobody
  function automatic int predict_winner(input logic ir, input logic mr);
    if (ir && mr) return m_last_mem ? 1 : 2;
    if (mr) return 2;
    if (ir) return 1;
    return 0;
  endfunction

  task automatic model_access(input int win, input logic we, input int dly,
                              input logic [DW-1:0] rd, output int exp_en);
    logic timed;
    timed  = !(dly >= 1 && dly <= TO);
    exp_en = timed ? TO : dly;
    m_last_mem = (win == 2);
    if (timed) m_err = 1'b1;
    if (win == 1) m_if_rdata = timed ? '0 : rd;
    else if (timed) m_mem_rdata = '0;
    else if (!we) m_mem_rdata = rd;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_reset();
  endtask

  // RAM responder: acks in the dly-th strobe cycle (never if 0 or beyond timeout)
  task automatic serve(input int dly, input logic [DW-1:0] rd,
                       output int en_cyc, output logic [AW-1:0] a_addr, output logic a_we,
                       output logic [DW-1:0] a_wdata, output int unstable,
                       output int stall_bad, output int who);
    en_cyc = 0; unstable = 0; stall_bad = 0; who = 0;
    a_addr = '0; a_we = 1'b0; a_wdata = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      ram_ack   = 1'b0;
      ram_rdata = $urandom;
      if (if_valid || mem_done) begin
        who = (if_valid ? 1 : 0) + (mem_done ? 2 : 0);
        if (ram_en) unstable++;
        break;
      end
      if (stall_mem !== mem_req || wb_bubble !== mem_req || stall_if !== (if_req | mem_req))
        stall_bad++;
      if (ram_en) begin
        en_cyc++;
        if (en_cyc == 1) begin
          a_addr = ram_addr; a_we = ram_we; a_wdata = ram_wdata;
        end else if (ram_addr !== a_addr || ram_we !== a_we || ram_wdata !== a_wdata) begin
          unstable++;
        end
        if (en_cyc == dly) begin
          ram_ack = 1'b1; ram_rdata = rd;
        end
      end
    end
    ram_ack = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; ram_ack = 1'b1; ram_rdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    total++; if (ram_en !== 1'b0)   begin bad++; $display("FAIL reset_ram_en got=%b exp=0", ram_en); end
    total++; if (ram_we !== 1'b0)   begin bad++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
    total++; if (ram_addr !== '0)   begin bad++; $display("FAIL reset_ram_addr got=%h exp=0", ram_addr); end
    total++; if (ram_wdata !== '0)  begin bad++; $display("FAIL reset_ram_wdata got=%h exp=0", ram_wdata); end
    total++; if (if_rdata !== '0)   begin bad++; $display("FAIL reset_if_rdata got=%h exp=0", if_rdata); end
    total++; if (mem_rdata !== '0)  begin bad++; $display("FAIL reset_mem_rdata got=%h exp=0", mem_rdata); end
    total++; if ({if_valid, mem_done} !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%b%b exp=00", if_valid, mem_done); end
    total++; if (err !== 1'b0)      begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    total++; if ({stall_if, stall_mem, wb_bubble} !== 3'b000) begin bad++; $display("FAIL reset_stalls got=%b%b%b exp=000", stall_if, stall_mem, wb_bubble); end
    clr = 1'b0; ram_ack = 1'b0;
    model_reset();
  endtask

  task automatic test_single_fetch();
    int en_cyc, unst, sbad, who, exp_en;
    logic [AW-1:0] a; logic w; logic [DW-1:0] wd;
    if_req = 1'b1; if_addr = 32'h40;
    model_access(1, 1'b0, 2, 32'h8C41_0004, exp_en);
    serve(2, 32'h8C41_0004, en_cyc, a, w, wd, unst, sbad, who);
    total++; if (who !== 1)       begin bad++; $display("FAIL fetch_pulse got=%0d exp=1", who); end
    total++; if (en_cyc !== 2)    begin bad++; $display("FAIL fetch_en_cycles got=%0d exp=2", en_cyc); end
    total++; if (a !== 32'h40 || w !== 1'b0) begin bad++; $display("FAIL fetch_addr_we got=%h/%b exp=40/0", a, w); end
    total++; if (unst !== 0 || sbad !== 0) begin bad++; $display("FAIL fetch_stable_stall got=%0d/%0d exp=0/0", unst, sbad); end
    total++; if (if_rdata !== 32'h8C41_0004) begin bad++; $display("FAIL fetch_rdata got=%h exp=8c410004", if_rdata); end
    if_req = 1'b0;
    @(negedge clk);
    total++; if ({if_valid, stall_if} !== 2'b00) begin bad++; $display("FAIL fetch_after got=%b%b exp=00", if_valid, stall_if); end
  endtask

  task automatic test_store();
    int en_cyc, unst, sbad, who, exp_en;
    logic [AW-1:0] a; logic w; logic [DW-1:0] wd;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h100; mem_wdata = 32'hDEAD_BEEF;
    model_access(2, 1'b1, 1, 32'h1234_5678, exp_en);
    serve(1, 32'h1234_5678, en_cyc, a, w, wd, unst, sbad, who);
    total++; if (who !== 2)    begin bad++; $display("FAIL store_pulse got=%0d exp=2", who); end
    total++; if (en_cyc !== 1) begin bad++; $display("FAIL store_en_cycles got=%0d exp=1", en_cyc); end
    total++; if (a !== 32'h100 || w !== 1'b1 || wd !== 32'hDEAD_BEEF)
      begin bad++; $display("FAIL store_bus got=%h/%b/%h exp=100/1/deadbeef", a, w, wd); end
    total++; if (unst !== 0 || sbad !== 0) begin bad++; $display("FAIL store_stable_stall got=%0d/%0d exp=0/0", unst, sbad); end
    total++; if (mem_rdata !== m_mem_rdata) begin bad++; $display("FAIL store_rdata got=%h exp=%h", mem_rdata, m_mem_rdata); end
    mem_req = 1'b0; mem_we = 1'b0;
  endtask

  task automatic test_contention();
    int en_cyc, unst, sbad, who, exp_en, win;
    logic [AW-1:0] a; logic w; logic [DW-1:0] wd, rd;
    do_clr();
    if_req = 1'b1; if_addr = 32'h200; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h300;
    for (int k = 0; k < 6; k++) begin
      win = (k % 2 == 0) ? 2 : 1;
      rd  = $urandom;
      model_access(win, 1'b0, 1, rd, exp_en);
      serve(1, rd, en_cyc, a, w, wd, unst, sbad, who);
      total++; if (who !== win) begin bad++; $display("FAIL contention_order k=%0d got=%0d exp=%0d", k, who, win); end
      total++; if ((win == 1 ? if_rdata : mem_rdata) !== rd)
        begin bad++; $display("FAIL contention_rdata k=%0d got=%h exp=%h", k, (win == 1 ? if_rdata : mem_rdata), rd); end
    end
    if_req = 1'b0; mem_req = 1'b0;
  endtask

  task automatic test_timeout();
    int en_cyc, unst, sbad, who, exp_en;
    logic [AW-1:0] a; logic w; logic [DW-1:0] wd;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h480;
    model_access(2, 1'b0, 0, '0, exp_en);
    serve(0, '0, en_cyc, a, w, wd, unst, sbad, who);
    mem_req = 1'b0;
    total++; if (who !== 2)         begin bad++; $display("FAIL timeout_pulse got=%0d exp=2", who); end
    total++; if (en_cyc !== TO)     begin bad++; $display("FAIL timeout_en_cycles got=%0d exp=%0d", en_cyc, TO); end
    total++; if (mem_rdata !== '0)  begin bad++; $display("FAIL timeout_rdata got=%h exp=0", mem_rdata); end
    total++; if (err !== 1'b1)      begin bad++; $display("FAIL timeout_err got=%b exp=1", err); end
    if_req = 1'b1; if_addr = 32'h44;
    model_access(1, 1'b0, 1, 32'h0000_0013, exp_en);
    serve(1, 32'h0000_0013, en_cyc, a, w, wd, unst, sbad, who);
    if_req = 1'b0;
    total++; if (err !== 1'b1 || if_rdata !== 32'h13) begin bad++; $display("FAIL timeout_sticky got=%b/%h exp=1/13", err, if_rdata); end
    do_clr();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL timeout_clr got=%b exp=0", err); end
  endtask

  task automatic test_reset_mid();
    int en_cyc, seen;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h500;
    en_cyc = 0;
    for (int c = 0; c < 20 && en_cyc < 2; c++) begin
      @(negedge clk);
      if (ram_en) en_cyc++;
    end
    total++; if (en_cyc !== 2) begin bad++; $display("FAIL midrst_busy got=%0d exp=2", en_cyc); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; mem_req = 1'b0; ram_ack = 1'b1; ram_rdata = 32'hCAFE_F00D;
    model_reset();
    total++; if (ram_en !== 1'b0 || mem_done !== 1'b0) begin bad++; $display("FAIL midrst_en got=%b/%b exp=0/0", ram_en, mem_done); end
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (mem_done || ram_en) seen++;
    end
    ram_ack = 1'b0;
    total++; if (seen !== 0) begin bad++; $display("FAIL midrst_late_ack got=%0d exp=0", seen); end
    total++; if (mem_rdata !== '0) begin bad++; $display("FAIL midrst_rdata got=%h exp=0", mem_rdata); end
  endtask

  task automatic test_random();
    int en_cyc, unst, sbad, who, exp_en, win, dly;
    logic [AW-1:0] a, exp_a; logic w, exp_w; logic [DW-1:0] wd, rd;
    logic ir, mr;
    ir = 1'b1; mr = 1'b1;
    if_addr = $urandom; mem_addr = $urandom; mem_we = $urandom_range(0, 1); mem_wdata = $urandom;
    for (int k = 0; k < 40; k++) begin
      if_req = ir; mem_req = mr;
      win   = predict_winner(ir, mr);
      exp_a = (win == 2) ? mem_addr : if_addr;
      exp_w = (win == 2) ? mem_we : 1'b0;
      dly   = $urandom_range(0, 6);
      rd    = $urandom;
      model_access(win, mem_we, dly, rd, exp_en);
      serve(dly, rd, en_cyc, a, w, wd, unst, sbad, who);
      total++; if (who !== win) begin bad++; $display("FAIL rand_grant k=%0d got=%0d exp=%0d", k, who, win); end
      total++; if (en_cyc !== exp_en || a !== exp_a || w !== exp_w)
        begin bad++; $display("FAIL rand_bus k=%0d got=%0d/%h/%b exp=%0d/%h/%b", k, en_cyc, a, w, exp_en, exp_a, exp_w); end
      total++; if (win == 2 && exp_w && wd !== mem_wdata)
        begin bad++; $display("FAIL rand_wdata k=%0d got=%h exp=%h", k, wd, mem_wdata); end
      total++; if (unst !== 0 || sbad !== 0) begin bad++; $display("FAIL rand_stable_stall k=%0d got=%0d/%0d exp=0/0", k, unst, sbad); end
      total++; if (if_rdata !== m_if_rdata || mem_rdata !== m_mem_rdata || err !== m_err)
        begin bad++; $display("FAIL rand_state k=%0d got=%h/%h/%b exp=%h/%h/%b", k, if_rdata, mem_rdata, err, m_if_rdata, m_mem_rdata, m_err); end
      // Winner issues a fresh (or no) request; the loser keeps waiting
      if (win == 1) begin ir = $urandom_range(0, 1); if_addr = $urandom; end
      else begin mr = $urandom_range(0, 1); mem_addr = $urandom; mem_we = $urandom_range(0, 1); mem_wdata = $urandom; end
      if (!ir && !mr) ir = 1'b1;
    end
    if_req = 1'b0; mem_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    clr = 1'b1; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0; ram_ack = 1'b0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0; ram_rdata = '0;
    model_reset();
    test_reset();
    test_single_fetch();
    test_store();
    test_contention();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the single-port data/instruction RAM between the IF stage (fetch) and the MEM stage (load/store) of the 5-stage pipeline.
- Sequences each variable-latency RAM access with a small FSM.
- Generates the stall and bubble controls for the pipeline registers, including the MEM/WB register, which loads a NOP while a memory access is outstanding.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 16, maximum busy cycles before an access is aborted; 0 disables the timeout

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_valid
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetched instruction
- if_valid  out  1  one-cycle pulse: if_rdata valid
- mem_req  in  1  load/store request; held until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  AW  data address
- mem_wdata  in  DW  store data
- mem_rdata  out  DW  load data
- mem_done  out  1  one-cycle pulse: access complete
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data
- ram_ack  in  1  RAM completion, valid only while ram_en=1
- stall_if  out  1  freeze PC and IF/ID
- stall_mem  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- wb_bubble  out  1  MEM/WB loads zeros (NOP) this cycle
- err  out  1  sticky timeout flag

Behaviour:
- Reset (clr=1 at a clk edge) takes effect at that edge:
  - state=IDLE, last_grant=IF
  - ram_en/ram_we=0, ram_addr/ram_wdata=0
  - if_rdata/mem_rdata=0, if_valid/mem_done=0, err=0, timeout counter=0
- Reset mid-access aborts the access. No done/valid pulse is produced. A late ram_ack is ignored.
- FSM states: IDLE, BUSY_IF, BUSY_MEM, DONE.
- IDLE arbitration:
  - Only mem_req: go BUSY_MEM.
  - Only if_req: go BUSY_IF.
  - Both: round-robin. Grant the side not in last_grant. Since last_grant resets to IF, MEM wins first.
  - On grant, register ram_addr, ram_we (mem_we for MEM, 0 for IF) and ram_wdata.
  - Set ram_en=1 in the cycle after the request is sampled; update last_grant.
- BUSY_x:
  - ram_en, ram_we, ram_addr and ram_wdata are held stable.
  - Counter increments each cycle.
  - ram_ack=1: capture ram_rdata into if_rdata or mem_rdata (store: mem_rdata unchanged), drop ram_en at the next edge, go DONE.
  - TIMEOUT≠0 and counter reaches TIMEOUT-1 with no ack: drop ram_en, set err=1 (sticky until clr), write 0 to the selected rdata, go DONE.
- DONE (1 cycle):
  - Pulse if_valid or mem_done for the granted side, then go IDLE.
  - Requests are re-arbitrated in IDLE, so minimum occupancy is 3 cycles per access when ack arrives in the first BUSY cycle.
- ram_ack is ignored in IDLE and DONE.
- Control outputs are combinational from registered state:
  - stall_mem = mem_req & ~mem_done
  - wb_bubble = stall_mem
  - stall_if = (if_req & ~if_valid) | stall_mem
- A request dropped in IDLE before grant is simply not served. Once granted, the access completes regardless of the requester's req level.
- Back-to-back: if both sides are requesting, grants alternate MEM, IF, MEM, IF… with no starvation.

Test Plan:
- Single fetch: if_req=1, if_addr=0x40; ram_ack after 2 BUSY cycles with rdata=0x8C410004 -> ram_en high for exactly 2 cycles with addr 0x40 and we=0; if_valid pulses with if_rdata=0x8C410004; stall_if high until that pulse.
- Store: mem_req=1, mem_we=1, addr=0x100, wdata=0xDEADBEEF, immediate ack -> ram_we=1 with stable addr/wdata; mem_done pulses; wb_bubble=1 every cycle before mem_done; stall_if=1 throughout.
- Contention: if_req and mem_req both asserted from reset -> MEM served first, then IF, then MEM again; grant order checked over 6 accesses.
- Timeout: TIMEOUT=4, mem load with no ack -> ram_en drops after 4 cycles; mem_done pulses with mem_rdata=0; err=1 and stays 1 until clr.
- Reset mid-access: clr in the 2nd BUSY_MEM cycle, then ram_ack -> at the next edge ram_en=0 and state IDLE; no mem_done pulse; mem_rdata=0.
